// File: rtl/store_buffer.sv
// Posted-write buffer: queues CPU stores in a FIFO and drains them in order to
// data memory over a req/ack handshake, stalling the CPU only on full or load hazard.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   memwrite,
   input  logic                   memread,
   input  logic [AW-1:0]          dataaddr,
   input  logic [DW-1:0]          writedata,
   output logic                   stall,
   output logic                   mem_req,
   output logic [AW-1:0]          mem_addr,
   output logic [DW-1:0]          mem_wdata,
   input  logic                   mem_ack,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   state_dbg
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   state_t          state;
   logic [AW-1:0]   addr_q [DEPTH];
   logic [DW-1:0]   data_q [DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   count_nxt;
   logic            full;
   logic            push;
   logic            pop;
   logic            hazard;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign state_dbg = (state == REQ);

   // Memory handshake: mem_req/mem_addr/mem_wdata stay stable while mem_req is
   // high; a store transfers on every rising edge where mem_req && mem_ack.
   // mem_ack with mem_req low has no effect.
   assign mem_req   = (state == REQ);
   assign mem_addr  = addr_q[head];
   assign mem_wdata = data_q[head];

   // Full is taken from the registered count, so a same-edge pop never admits a push.
   assign push      = memwrite && !full;
   assign pop       = mem_req && mem_ack;
   assign count_nxt = count_q + CW'(push) - CW'(pop);

   always_comb begin
      logic [PW-1:0] off;
      off    = '0;
      hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         off = PW'(i) - head;
         if ((CW'(off) < count_q) && (addr_q[i][AW-1:2] == dataaddr[AW-1:2]))
            hazard = 1'b1;
      end
   end

   assign stall = (memwrite && full) || (memread && hazard);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (push) begin
            addr_q[tail] <= dataaddr;
            data_q[tail] <= writedata;
            tail         <= tail + 1'b1;
         end
         if (pop)
            head <= head + 1'b1;
         count_q <= count_nxt;
         case (state)
            IDLE: if (!empty) state <= REQ;
            REQ:  if (mem_ack && (count_nxt == '0)) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: hand-computed checks plus an in-order
// scoreboard of every store accepted by memory.
module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;

   logic          clk;
   logic          reset;
   logic          memwrite;
   logic          memread;
   logic [AW-1:0] dataaddr;
   logic [DW-1:0] writedata;
   logic          stall;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack;
   logic          empty;
   logic [2:0]    count;
   logic          state_dbg;

   int n_checks = 0;
   int n_errors = 0;
   logic [AW+DW-1:0] exp_q[$];

   store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset), .memwrite(memwrite), .memread(memread),
      .dataaddr(dataaddr), .writedata(writedata), .stall(stall),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .empty(empty), .count(count), .state_dbg(state_dbg)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
      memwrite  = 1'b1;
      dataaddr  = a;
      writedata = d;
      exp_q.push_back({a, d});
      tick();
      memwrite  = 1'b0;
   endtask

   // scoreboard: inputs are stable at negedge, so a handshake seen here completes next edge
   always @(negedge clk) begin
      if (reset && mem_req && mem_ack) begin
         if (exp_q.size() == 0) begin
            check("drain_unexpected", {mem_addr, mem_wdata}, 64'hDEAD);
         end else begin
            check("drain_order", {mem_addr, mem_wdata}, exp_q.pop_front());
         end
      end
   end

   initial begin
      reset = 1'b0; memwrite = 1'b1; memread = 1'b0;
      dataaddr = 32'h54; writedata = 32'h3; mem_ack = 1'b0;

      // reset with a store request pending
      #3;
      check("rst_mem_req", mem_req, 0);
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_stall", stall, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_state", state_dbg, 0);
      memwrite = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick(); tick();
      check("post_rst_req", mem_req, 0);
      check("post_rst_count", count, 0);

      // single store with two wait states
      push_store(32'h54, 32'h3);
      check("single_count", count, 1);
      check("single_req_t0", mem_req, 0);
      tick();
      check("single_req", mem_req, 1);
      check("single_addr", mem_addr, 32'h54);
      check("single_data", mem_wdata, 3);
      tick(); tick();
      check("single_hold_addr", mem_addr, 32'h54);
      check("single_hold_data", mem_wdata, 3);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("single_done_count", count, 0);
      check("single_done_empty", empty, 1);
      check("single_done_req", mem_req, 0);

      // fill to DEPTH, then a stalled fifth store
      for (int i = 0; i < 4; i++) push_store(32'h10 + 32'(4 * i), 32'(i + 1));
      check("full_count", count, 4);
      memwrite = 1'b1; dataaddr = 32'h20; writedata = 32'h5;
      #1;
      check("full_stall", stall, 1);
      tick();
      check("full_count_hold", count, 4);
      check("full_head", mem_addr, 32'h10);
      mem_ack = 1'b1;
      #1;
      check("full_stall_ack_cycle", stall, 1);
      tick();
      mem_ack = 1'b0;
      #1;
      check("full_next_head", mem_addr, 32'h14);
      check("full_stall_clear", stall, 0);
      check("full_count_after_pop", count, 3);
      exp_q.push_back({32'h20, 32'h5});
      tick();
      memwrite = 1'b0;
      check("full_fifth_accepted", count, 4);
      mem_ack = 1'b1;
      check("full_drain_head2", mem_wdata, 2);
      tick();
      check("full_drain_head3", mem_wdata, 3);
      tick(); tick(); tick();
      mem_ack = 1'b0;
      check("full_drained", count, 0);
      check("full_drained_req", mem_req, 0);

      // load hazard on a queued word
      push_store(32'h100, 32'hAA);
      tick();
      memread = 1'b1; dataaddr = 32'h102;
      #1;
      check("hazard_match", stall, 1);
      dataaddr = 32'h104;
      #1;
      check("hazard_other_word", stall, 0);
      dataaddr = 32'h102; mem_ack = 1'b1;
      #1;
      check("hazard_ack_cycle", stall, 1);
      tick();
      mem_ack = 1'b0;
      #1;
      check("hazard_cleared", stall, 0);
      memread = 1'b0;
      tick();

      // back-to-back drain with ack tied high, twice to exercise wrap-around
      mem_ack = 1'b1;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 3; i++) begin
            memwrite = 1'b1; dataaddr = 32'h20 + 32'(4 * i); writedata = 32'(7 + i);
            exp_q.push_back({dataaddr, writedata});
            tick();
            if (i == 1) check("b2b_first", mem_wdata, 7);
            if (i == 2) check("b2b_second", mem_wdata, 8);
         end
         memwrite = 1'b0;
         check("b2b_req_mid", mem_req, 1);
         tick();
         check("b2b_third", mem_wdata, 9);
         tick();
         check("b2b_req_fall", mem_req, 0);
         check("b2b_empty", empty, 1);
      end
      mem_ack = 1'b0;
      check("scoreboard_empty", exp_q.size(), 0);

      // reset in the middle of a request
      push_store(32'h30, 32'h1);
      push_store(32'h34, 32'h2);
      check("midrst_req", mem_req, 1);
      check("midrst_count", count, 2);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_req_drop", mem_req, 0);
      check("midrst_count_clr", count, 0);
      check("midrst_stall", stall, 0);
      exp_q.delete();
      tick();
      reset = 1'b1;
      tick(); tick(); tick();
      check("midrst_no_req", mem_req, 0);
      check("midrst_still_empty", empty, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the multi-cycle CPU's data port (`memwrite`, `dataaddr`, `writedata`) and the data memory. It accepts CPU stores in a single cycle, queues them in a FIFO, and drains them in order to memory over a req/ack handshake, so memory wait states do not stretch the CPU's store states. The CPU is stalled only when the FIFO is full or a load hits a word still waiting in the buffer.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2
- `AW`, 32: address width
- `DW`, 32: data width
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `memwrite`  in  1  CPU store request this cycle
- `memread`  in  1  CPU load request this cycle
- `dataaddr`  in  AW  CPU byte address (store or load)
- `writedata`  in  DW  CPU store data
- `stall`  out  1  CPU must hold its current state and request
- `mem_req`  out  1  store presented to memory
- `mem_addr`  out  AW  head-entry address
- `mem_wdata`  out  DW  head-entry data
- `mem_ack`  in  1  memory accepted the presented store this cycle
- `empty`  out  1  no queued stores
- `count`  out  $clog2(DEPTH)+1  number of queued stores

## Operation
- Storage: DEPTH entries {addr, data}, head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, registered `count`.
- full = (count == DEPTH); empty = (count == 0).
- Push: `memwrite && !full` at a clock edge writes {dataaddr, writedata} at tail, tail+1.
- Store stall: `memwrite && full`. Full is evaluated on the registered count; a same-cycle pop does not admit a push.
- Load hazard: `memread` with any valid entry where addr[AW-1:2] == dataaddr[AW-1:2] (word match; byte offset ignored) -> stall until no matching entry remains.
- `stall` = store stall OR load hazard; combinational from inputs and registered state.
- `memread && memwrite` in the same cycle is illegal CPU behaviour; behaviour is unspecified.
- Drain FSM, two states:
  - IDLE: `mem_req`=0. If !empty -> REQ.
  - REQ: `mem_req`=1; `mem_addr`/`mem_wdata` driven from the head entry and held stable until ack. On `mem_ack`: pop (head+1). If count after the pop (including a same-edge push) is nonzero, stay in REQ and present the new head; otherwise go to IDLE.
- Pop and push on the same edge: count unchanged; both pointers advance.
- `mem_ack` while `mem_req`=0 is ignored.
- Stores leave strictly in FIFO order; no merging or coalescing.

## Timing
- Reset (asynchronous assertion, synchronous effect on release): state IDLE, head=tail=0, count=0, entries cleared to 0, `mem_req`=0, `mem_addr`=0, `mem_wdata`=0, `empty`=1. `stall`=0 for any inputs, because the buffer is empty.
- Reset mid-operation drops queued and in-flight stores immediately; `mem_req` falls without waiting for a clock edge.
- Latency:
  - Store pushed at edge t0 -> `mem_req` high after edge t0+1.
  - Ack sampled at edge t1 -> pop at t1; next head presented after t1 with no bubble.
- Throughput: with `mem_ack` held at 1, one store drains per cycle.
- Stall release:
  - Full stall clears in the cycle after the ack edge.
  - Hazard stall clears in the cycle after the edge that pops the last matching entry.

## Test plan
- Reset: drive `reset`=0 with `memwrite`=1 -> `mem_req`=0, `count`=0, `empty`=1, `stall`=0, `mem_addr`=0; release `reset` -> still idle.
- Single store with wait states: push addr 0x54, data 3 at t0 -> after t0+1, `mem_req`=1, `mem_addr`=0x54, `mem_wdata`=3, held through 2 wait cycles; `mem_ack` pulse -> `count`=0, `empty`=1, `mem_req`=0 next cycle.
- Full: DEPTH=4, `mem_ack`=0, push 0x10/0x14/0x18/0x1C with data 1..4 -> `count`=4. Fifth `memwrite` -> `stall`=1, `count` stays 4. One ack -> `mem_addr` becomes 0x14, `stall`=0 next cycle, fifth store accepted.
- Load hazard: 0x100 queued, ack held off. `memread`, addr 0x102 -> `stall`=1. `memread`, addr 0x104 -> `stall`=0. Ack 0x100 -> `stall` drops the next cycle.
- Back-to-back drain: push 0x20/0x24/0x28 (data 7/8/9), `mem_ack` tied 1 -> data 7, 8, 9 appear on consecutive cycles in order; `mem_req` falls after the third; wrap-around verified by repeating twice.
- Reset mid-REQ: 2 entries queued, `mem_req`=1; assert `reset` between edges -> `mem_req`=0 immediately, `count`=0; after release no further requests.
